// File: rtl/overdrive_pkg.sv
// Shared definitions for the overdrive chain: default scales, gain FSM states,
// and the saturation helper reused by the clamp stage.
package overdrive_pkg;

  localparam int unsigned BitsPerLevelDefault = 12;
  localparam int unsigned GainFracDefault     = 8;

  typedef enum logic [0:0] {
    StIdle,
    StRamp
  } gain_state_e;

  // Clamp a wide signed value to [-limit, +limit] and narrow it to a sample.
  function automatic logic signed [31:0] saturate(input logic signed [47:0] value,
                                                  input logic signed [47:0] limit);
    logic signed [47:0] clamped;
    if (value > limit) begin
      clamped = limit;
    end else if (value < -limit) begin
      clamped = -limit;
    end else begin
      clamped = value;
    end
    return 32'(clamped);
  endfunction

endpackage

// File: rtl/overdrive_gain_ramp.sv
// Gain FSM: latches requested gain targets and walks the applied gain toward
// them by a fixed step, one step per accepted input sample.
module overdrive_gain_ramp
  import overdrive_pkg::*;
#(
  parameter int unsigned GAIN_FRAC = GainFracDefault,
  parameter int unsigned RAMP_STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] gain_target,
  input  logic        gain_load,
  input  logic        step_en,
  output logic [15:0] gain_current,
  output logic        ramping
);

  localparam logic [15:0] UnityGain = 16'(1 << GAIN_FRAC);
  localparam logic [16:0] StepW     = 17'(RAMP_STEP);

  gain_state_e state_q, state_d;
  logic [15:0] gain_q, gain_d;
  logic [15:0] target_q, target_d;
  logic [15:0] gain_stepped;
  logic [16:0] gap;

  // One step toward the latched target, clamped so it never overshoots.
  always_comb begin
    gain_stepped = gain_q;
    gap          = 17'd0;
    if (target_q > gain_q) begin
      gap          = {1'b0, target_q} - {1'b0, gain_q};
      gain_stepped = (gap > StepW) ? 16'({1'b0, gain_q} + StepW) : target_q;
    end else if (target_q < gain_q) begin
      gap          = {1'b0, gain_q} - {1'b0, target_q};
      gain_stepped = (gap > StepW) ? 16'({1'b0, gain_q} - StepW) : target_q;
    end
  end

  // Next state: a step uses the old target; a same-edge load only affects later steps.
  always_comb begin
    state_d  = state_q;
    gain_d   = gain_q;
    target_d = target_q;
    unique case (state_q)
      StIdle: begin
        if (gain_load) begin
          target_d = gain_target;
          if (gain_target != gain_q) begin
            state_d = StRamp;
          end
        end
      end
      StRamp: begin
        if (step_en) begin
          gain_d = gain_stepped;
        end
        if (gain_load) begin
          target_d = gain_target;
        end
        if (gain_d == target_d) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Gain FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      gain_q   <= UnityGain;
      target_q <= UnityGain;
    end else begin
      state_q  <= state_d;
      gain_q   <= gain_d;
      target_q <= target_d;
    end
  end

  assign gain_current = gain_q;
  assign ramping      = (state_q == StRamp);

endmodule

// File: rtl/overdrive_pregain.sv
// Pre-gain stage ahead of the overdrive clamp: two-stage multiply / shift-and-
// saturate pipeline with valid/ready on both sides and a ramped gain.
module overdrive_pregain
  import overdrive_pkg::*;
#(
  parameter int unsigned BITS_PER_LEVEL = BitsPerLevelDefault,
  parameter int unsigned GAIN_FRAC      = GainFracDefault,
  parameter int unsigned RAMP_STEP      = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] in_sample,
  input  logic        [15:0] gain_target,
  input  logic               gain_load,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [31:0] out_sample,
  output logic        [15:0] gain_current,
  output logic               ramping
);

  localparam int unsigned        SatShift = BITS_PER_LEVEL + 2;
  localparam logic signed [47:0] SatLimit = 48'(longint'(1) << SatShift);

  logic               advance;
  logic               in_xfer;
  logic               s1_valid_q, s1_valid_d;
  logic signed [47:0] prod_q, prod_d;
  logic               out_valid_q, out_valid_d;
  logic signed [31:0] out_sample_q, out_sample_d;
  logic signed [47:0] sample_ext;
  logic signed [47:0] gain_ext;
  logic signed [47:0] shifted;

  // Whole pipeline moves together; a stalled output freezes both stages.
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;
  assign in_xfer  = in_valid && advance;

  overdrive_gain_ramp #(
    .GAIN_FRAC (GAIN_FRAC),
    .RAMP_STEP (RAMP_STEP)
  ) u_gain_ramp (
    .clk          (clk),
    .rst          (rst),
    .gain_target  (gain_target),
    .gain_load    (gain_load),
    .step_en      (in_xfer),
    .gain_current (gain_current),
    .ramping      (ramping)
  );

  // Next state for both pipeline stages; bubbles clear the valid bits.
  always_comb begin
    sample_ext   = {{16{in_sample[31]}}, in_sample};
    gain_ext     = {32'd0, gain_current};
    shifted      = prod_q >>> GAIN_FRAC;
    s1_valid_d   = s1_valid_q;
    prod_d       = prod_q;
    out_valid_d  = out_valid_q;
    out_sample_d = out_sample_q;
    if (advance) begin
      s1_valid_d  = in_valid;
      out_valid_d = s1_valid_q;
      if (in_valid) begin
        prod_d = sample_ext * gain_ext;
      end
      if (s1_valid_q) begin
        out_sample_d = saturate(shifted, SatLimit);
      end
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      prod_q       <= '0;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      prod_q       <= prod_d;
      out_valid_q  <= out_valid_d;
      out_sample_q <= out_sample_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sample = out_sample_q;

endmodule

// File: tb/tb_overdrive_pregain.sv
// Self-checking bench for overdrive_pregain: directed scenarios plus random
// traffic against a plain arithmetic reference model with an expected-output queue.
module tb_overdrive_pregain;

  localparam int Unity = 256;
  localparam int Sat   = 16384;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_sample;
  logic        [15:0] gain_target;
  logic               gain_load;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_sample;
  logic        [15:0] gain_current;
  logic               ramping;

  overdrive_pregain dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sample    (in_sample),
    .gain_target  (gain_target),
    .gain_load    (gain_load),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sample   (out_sample),
    .gain_current (gain_current),
    .ramping      (ramping)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  int m_gain;
  int m_target;
  bit m_ramp;
  int exp_q[$];
  int out_log[$];

  // Observations taken mid-cycle by drive_cycle.
  bit obs_out_valid;
  int obs_out_sample;
  bit obs_in_ready;
  bit obs_ramping;
  bit obs_xfer;
  bit prev_stall;
  int prev_sample;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_out(input int s, input int g);
    longint p, q;
    p = longint'(s) * longint'(g);
    q = p / 256;
    if (p < 0 && (p % 256) != 0) q = q - 1;
    if (q > Sat) q = Sat;
    else if (q < -Sat) q = -Sat;
    return int'(q);
  endfunction

  task automatic model_reset();
    m_gain   = Unity;
    m_target = Unity;
    m_ramp   = 0;
    exp_q.delete();
    out_log.delete();
    prev_stall = 0;
  endtask

  task automatic model_edge(input bit load, input int tgt, input bit xfer);
    if (!m_ramp) begin
      if (load) begin
        m_target = tgt;
        m_ramp   = (tgt != m_gain);
      end
    end else begin
      if (xfer) begin
        if (m_gain < m_target) m_gain = m_gain + 1;
        else if (m_gain > m_target) m_gain = m_gain - 1;
      end
      if (load) m_target = tgt;
      if (m_gain == m_target) m_ramp = 0;
    end
  endtask

  // Drive one cycle of inputs, check outputs against the model, advance one edge.
  task automatic drive_cycle(input bit iv, input int smp, input bit ordy, input bit gl,
                             input int gt);
    @(negedge clk);
    in_valid    = iv;
    in_sample   = smp;
    out_ready   = ordy;
    gain_load   = gl;
    gain_target = 16'(gt);
    #1;
    obs_out_valid  = out_valid;
    obs_out_sample = out_sample;
    obs_in_ready   = in_ready;
    obs_ramping    = ramping;
    check("gain_current", gain_current, m_gain);
    check("ramping", ramping, m_ramp);
    check("in_ready", in_ready, !out_valid || ordy);
    if (prev_stall) begin
      check("stall_valid", out_valid, 1);
      check("stall_hold", out_sample, prev_sample);
    end
    prev_stall  = out_valid && !ordy;
    prev_sample = out_sample;
    if (out_valid && ordy) begin
      out_log.push_back(out_sample);
      if (exp_q.size() == 0) check("spurious_out", out_sample, 32'h7fffffff);
      else check("out_sample", out_sample, exp_q.pop_front());
    end
    obs_xfer = iv && in_ready;
    if (obs_xfer) exp_q.push_back(model_out(smp, m_gain));
    model_edge(gl, gt, obs_xfer);
    @(posedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) drive_cycle(0, 0, 1, 0, 0);
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic settle();
    for (int i = 0; i < 2000 && m_ramp; i++) drive_cycle(1, 0, 1, 0, 0);
    drive_cycle(0, 0, 1, 0, 0);
    check("settled", obs_ramping, 0);
    drain();
    out_log.delete();
  endtask

  // Asynchronous reset mid-cycle; effects must appear before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_gain", gain_current, Unity);
    check("rst_ramping", ramping, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sample", out_sample, 0);
    in_valid  = 1'b0;
    gain_load = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int pend[$];
    rst = 1'b1;
    in_valid = 0; in_sample = 0; out_ready = 0; gain_load = 0; gain_target = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Unity gain, latency and first-cycle ready.
    drive_cycle(1, 1000, 1, 0, 0);
    check("ready_after_reset", obs_in_ready, 1);
    drive_cycle(0, 0, 1, 0, 0);
    check("lat_stage1", obs_out_valid, 0);
    drive_cycle(0, 0, 1, 0, 0);
    check("lat_stage2", obs_out_valid, 1);
    check("unity_1000", obs_out_sample, 1000);
    drain();
    out_log.delete();

    // Gain 4.0 saturates both ways.
    drive_cycle(0, 0, 1, 1, 1024);
    settle();
    drive_cycle(1, 10000, 1, 0, 0);
    drive_cycle(1, -10000, 1, 0, 0);
    drain();
    check("sat_count", out_log.size(), 2);
    if (out_log.size() == 2) begin
      check("sat_pos", out_log[0], Sat);
      check("sat_neg", out_log[1], -Sat);
    end

    // Gain 0.5 floors toward minus infinity.
    do_reset();
    drive_cycle(0, 0, 1, 1, 128);
    settle();
    drive_cycle(1, -3, 1, 0, 0);
    drive_cycle(1, 3, 1, 0, 0);
    drain();
    check("half_count", out_log.size(), 2);
    if (out_log.size() == 2) begin
      check("half_neg3", out_log[0], -2);
      check("half_pos3", out_log[1], 1);
    end

    // Ramp 256 -> 260 one step per transfer.
    do_reset();
    drive_cycle(0, 0, 1, 1, 260);
    drive_cycle(0, 0, 1, 0, 0);
    check("ramp_started", obs_ramping, 1);
    for (int i = 0; i < 4; i++) drive_cycle(1, 256, 1, 0, 0);
    drive_cycle(0, 0, 1, 0, 0);
    check("ramp_done", obs_ramping, 0);
    drive_cycle(1, 256, 1, 0, 0);
    drain();
    check("ramp_count", out_log.size(), 5);
    for (int i = 0; i < 5 && i < out_log.size(); i++) check("ramp_gain_used", out_log[i], 256 + i);

    // Back-pressure: five stalled cycles with three samples offered.
    do_reset();
    pend = '{11, 22, 33};
    for (int i = 0; i < 5; i++) begin
      drive_cycle(pend.size() > 0, pend.size() > 0 ? pend[0] : 0, 0, 0, 0);
      if (obs_xfer) void'(pend.pop_front());
    end
    check("stall_accepted", pend.size(), 1);
    for (int i = 0; i < 10 && pend.size() > 0; i++) begin
      drive_cycle(1, pend[0], 1, 0, 0);
      if (obs_xfer) void'(pend.pop_front());
    end
    drain();
    check("stall_count", out_log.size(), 3);
    for (int i = 0; i < 3 && i < out_log.size(); i++) check("stall_order", out_log[i], 11 * (i + 1));

    // Reset mid-ramp with two samples in flight.
    do_reset();
    drive_cycle(0, 0, 1, 1, 260);
    drive_cycle(1, 500, 0, 0, 0);
    drive_cycle(1, 600, 0, 0, 0);
    do_reset();
    drive_cycle(0, 0, 0, 0, 0);
    check("ready_after_rst2", obs_in_ready, 1);
    for (int i = 0; i < 4; i++) drive_cycle(0, 0, 1, 0, 0);
    check("no_stale", out_log.size(), 0);

    // Random traffic with occasional gain loads.
    for (int i = 0; i < 3000; i++) begin
      bit iv, ordy, gl;
      int smp, gt;
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 3) != 0);
      gl   = ($urandom_range(0, 19) == 0);
      gt   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(200, 600));
      smp  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 40000)) - 20000
                                         : int'($urandom);
      drive_cycle(iv, smp, ordy, gl, gt);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
